serial_sub_ctrl: RTL and testbench

Bit-serial N-bit subtractor controller that sequences the existing 1-bit full subtractor `binary_sub` (d = x−y−z, b = borrow-out) over WIDTH clock cycles. It computes a − b − bin one bit per cycle, LSB first, carrying the borrow in a register between cycles. A start/busy/done handshake wraps the operation. It sits between a requester issuing subtract commands and the single shared `binary_sub` cell, and gives multi-bit subtraction at one-cell area cost.

---
 rtl/sub_pkg.sv | 12 +
 rtl/binary_sub.sv | 13 +
 rtl/serial_sub_ctrl.sv | 90 +++++++++
 tb/tb_serial_sub_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// rtl/sub_pkg.sv - shared state encoding and default width for the serial subtractor
package sub_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/binary_sub.sv
// rtl/binary_sub.sv - 1-bit full subtractor cell, d = x - y - z with borrow-out b
module binary_sub (
    output logic d,
    output logic b,
    input  logic x,
    input  logic y,
    input  logic z
);

    assign d = x ^ y ^ z;
    assign b = (~x & (y | z)) | (y & z);

endmodule

// File: rtl/serial_sub_ctrl.sv
// rtl/serial_sub_ctrl.sv - bit-serial WIDTH-bit subtractor sequencing one binary_sub cell, LSB first
module serial_sub_ctrl
    import sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             brw;
    logic [CW-1:0]    count;
    logic             cell_d;
    logic             cell_b;

    binary_sub u_cell (
        .d (cell_d),
        .b (cell_b),
        .x (a_sh[0]),
        .y (b_sh[0]),
        .z (brw)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            brw   <= 1'b0;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        brw   <= bin;
                        count <= '0;
                        diff  <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // cell result enters at the MSB so the LSB-first stream lands in order
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    diff  <= {cell_d, diff[WIDTH-1:1]};
                    brw   <= cell_b;
                    count <= count + CW'(1);
                    if (count == LAST_BIT) begin
                        bout  <= cell_b;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb/tb_serial_sub_ctrl.sv - randomized self-checking bench for serial_sub_ctrl
module tb_serial_sub_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;

    int checks;
    int errors;

    // reference model state: one operation in flight, tracked by cycles since acceptance
    bit           m_act;
    int           m_cnt;
    logic [W-1:0] m_a;
    logic [W-1:0] m_b;
    logic         m_bin;
    logic [W-1:0] m_diff;
    logic         m_bout;

    int           done_seen;
    int           busy_seen;
    logic [W-1:0] last_diff;
    logic         last_bout;

    serial_sub_ctrl #(.WIDTH(W)) dut (
        .clock (clk),
        .reset (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        logic [W:0] full;
        @(posedge clk);
        if (!rst_n) begin
            m_act  = 1'b0;
            m_cnt  = 0;
            m_diff = '0;
            m_bout = 1'b0;
        end else if (!m_act) begin
            if (start) begin
                m_act = 1'b1;
                m_cnt = 0;
                m_a   = a;
                m_b   = b;
                m_bin = bin;
            end
        end else begin
            m_cnt++;
            if (m_cnt == W) begin
                full   = {1'b0, m_a} - {1'b0, m_b} - {{W{1'b0}}, m_bin};
                m_diff = full[W-1:0];
                m_bout = full[W];
            end
            if (m_cnt == W + 1)
                m_act = 1'b0;
        end
        @(negedge clk);
        check_eq("busy", {31'b0, busy}, {31'b0, m_act});
        check_eq("done", {31'b0, done}, {31'b0, (m_act && m_cnt == W)});
        if (!m_act || m_cnt == W) begin
            check_eq("diff", {24'b0, diff}, {24'b0, m_diff});
            check_eq("bout", {31'b0, bout}, {31'b0, m_bout});
        end
        if (done) begin
            done_seen++;
            last_diff = diff;
            last_bout = bout;
        end
        if (busy)
            busy_seen++;
    endtask

    task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic obin,
                          input logic [W-1:0] ediff, input logic ebout, input string tag);
        int d0;
        int b0;
        d0 = done_seen;
        b0 = busy_seen;
        a = oa; b = ob; bin = obin; start = 1'b1;
        cycle();
        start = 1'b0; a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
        repeat (W + 2) cycle();
        check_eq({tag, "_diff"}, {24'b0, last_diff}, {24'b0, ediff});
        check_eq({tag, "_bout"}, {31'b0, last_bout}, {31'b0, ebout});
        check_eq({tag, "_ndone"}, done_seen - d0, 1);
        check_eq({tag, "_nbusy"}, busy_seen - b0, W + 1);
    endtask

    initial begin
        int d0;
        checks = 0; errors = 0;
        m_act = 0; m_cnt = 0; m_a = '0; m_b = '0; m_bin = 0; m_diff = '0; m_bout = 0;
        done_seen = 0; busy_seen = 0; last_diff = '0; last_bout = 0;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (2) cycle();
        check_eq("rst_busy", {31'b0, busy}, 32'd0);
        check_eq("rst_diff", {24'b0, diff}, 32'd0);
        rst_n = 1'b1;
        cycle();

        run_op(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, "t5a3c");
        run_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, "t0001");
        run_op(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, "t100f");
        run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "tffff");
        run_op(8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, "tff00");

        // start held high with operands changing every cycle
        d0 = done_seen;
        start = 1'b1;
        for (int i = 0; i < 6 * (W + 1); i++) begin
            a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
            cycle();
        end
        start = 1'b0;
        repeat (W + 2) cycle();
        check_eq("held_ndone", done_seen - d0, 6);

        // reset at E4 mid-SHIFT discards the operation
        d0 = done_seen;
        a = 8'h77; b = 8'h12; bin = 1'b0; start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (3) cycle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        check_eq("midrst_busy", {31'b0, busy}, 32'd0);
        check_eq("midrst_diff", {24'b0, diff}, 32'd0);
        check_eq("midrst_bout", {31'b0, bout}, 32'd0);
        repeat (W + 2) cycle();
        check_eq("midrst_ndone", done_seen - d0, 0);
        run_op(8'h80, 8'h01, 1'b1, 8'h7E, 1'b0, "tpost");

        // reset and start on the same edge
        d0 = done_seen;
        rst_n = 1'b0; start = 1'b1; a = 8'h33; b = 8'h11;
        cycle();
        rst_n = 1'b1; start = 1'b0;
        check_eq("rststart_busy", {31'b0, busy}, 32'd0);
        repeat (W + 2) cycle();
        check_eq("rststart_ndone", done_seen - d0, 0);

        // random traffic with sporadic starts and occasional resets
        for (int i = 0; i < 4000; i++) begin
            start = ($urandom_range(0, 2) == 0);
            a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
            rst_n = ($urandom_range(0, 199) != 0);
            cycle();
        end
        rst_n = 1'b1; start = 1'b0;
        repeat (W + 2) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
